ball_engine: RTL



---
 rtl/ball_engine_pkg.sv | 34 +++
 rtl/ball_engine_if.sv | 29 ++
 rtl/ball_engine_box_hit.sv | 20 ++
 rtl/ball_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ball_engine_pkg.sv
// Shared types and constants for the ball engine and its neighbours.
// Coordinates are 10-bit unsigned on the wire; motion arithmetic is done
// in a wider signed type so that stepping past an edge never wraps.
package ball_engine_pkg;

  localparam int COORD_W      = 10;
  localparam int CALC_W       = 12;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [COORD_W-1:0]       coord_t;
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    MISS = 2'd2
  } state_t;

  // Positive = right / down, negative = left / up.
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  function automatic calc_t to_calc(input coord_t c);
    return calc_t'({{(CALC_W-COORD_W){1'b0}}, c});
  endfunction

  function automatic calc_t advance(input coord_t p, input dir_t d, input calc_t s);
    return (d == DIR_NEG) ? to_calc(p) - s : to_calc(p) + s;
  endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Video-timing, paddle and game-control signals around the ball engine.
// slave: the ball engine. master: whoever drives timing, paddle and serve.
interface ball_engine_if;
  import ball_engine_pkg::*;

  logic   frame_tick;
  coord_t h_count;
  coord_t v_count;
  coord_t paddle_x;
  coord_t paddle_y;
  logic   serve;
  coord_t ball_x;
  coord_t ball_y;
  logic   pix_on;
  logic   hit;
  logic   miss;
  logic   busy;

  modport master (
    output frame_tick, h_count, v_count, paddle_x, paddle_y, serve,
    input  ball_x, ball_y, pix_on, hit, miss, busy
  );

  modport slave (
    input  frame_tick, h_count, v_count, paddle_x, paddle_y, serve,
    output ball_x, ball_y, pix_on, hit, miss, busy
  );

endinterface

// File: rtl/ball_engine_box_hit.sv
// Combinational overlap test of two half-open rectangles
// [x, x+w) x [y, y+h). A point is a 1x1 rectangle.
module box_hit
  import ball_engine_pkg::*;
(
  input  calc_t a_x,
  input  calc_t a_y,
  input  calc_t a_w,
  input  calc_t a_h,
  input  calc_t b_x,
  input  calc_t b_y,
  input  calc_t b_w,
  input  calc_t b_h,
  output logic  hit
);

  assign hit = (a_x < b_x + b_w) && (b_x < a_x + a_w) &&
               (a_y < b_y + b_h) && (b_y < a_y + a_h);

endmodule

// File: rtl/ball_engine.sv
// Ball engine: owns ball position/velocity, advances once per frame_tick,
// bounces off left/right/top walls and the paddle, reports hit/miss and
// drives a registered in-ball pixel flag (1 clk latency).
// Optional feature: define SPEEDUP_EN to raise speed by one on every paddle
// hit, capped at MAX_STEP; otherwise speed is the constant STEP.
module ball_engine
  import ball_engine_pkg::*;
#(
  parameter int SIZE     = 10,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int X_INIT   = 315,
  parameter int Y_INIT   = 235,
  parameter int STEP     = 2,
  parameter int MAX_STEP = 6,
  parameter int PADDLE_W = 60,
  parameter int PADDLE_H = 10
) (
  input  logic          clk,
  input  logic          reset,
  ball_engine_if.slave  bus
);

  localparam calc_t SIZE_C  = calc_t'(SIZE);
  localparam calc_t X_MAX_C = calc_t'(H_ACTIVE - SIZE);
  localparam calc_t V_C     = calc_t'(V_ACTIVE);
  localparam coord_t X_RST  = coord_t'(X_INIT);
  localparam coord_t Y_RST  = coord_t'(Y_INIT);

  state_t state_q, state_d;
  coord_t x_q, y_q, x_n, y_n;
  dir_t   dx_q, dy_q, dx_n, dy_n;
  calc_t  speed;
  calc_t  nx, ny;
  logic   move_tick;
  logic   paddle_overlap;
  logic   bounce;
  logic   fall_out;
  logic   pix_hit;
  logic   hit_q;
  logic   pix_q;
  logic   busy;
  logic   miss;

  assign move_tick = (state_q == MOVE) && bus.frame_tick;
  assign nx        = advance(x_q, dx_q, speed);
  assign ny        = advance(y_q, dy_q, speed);

`ifdef SPEEDUP_EN
  calc_t speed_q;

  // Speed grows on each paddle bounce up to the ceiling, restarts on miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q <= calc_t'(STEP);
    end else if (state_q == MISS) begin
      speed_q <= calc_t'(STEP);
    end else if (move_tick && bounce) begin
      speed_q <= (speed_q >= calc_t'(MAX_STEP)) ? calc_t'(MAX_STEP) : speed_q + calc_t'(1);
    end
  end

  assign speed = speed_q;
`else
  logic unused_max_step;

  // The ceiling only matters when speed can grow.
  assign unused_max_step = ^32'(MAX_STEP);
  assign speed           = calc_t'(STEP);
`endif

  // Paddle test swept over this frame's vertical travel: the ball bottom
  // runs from y+SIZE to ny+SIZE (inclusive), which must touch the paddle
  // band [paddle_y, paddle_y+PADDLE_H]; horizontally it is a plain overlap
  // at the new x. Only meaningful while moving down (ny = y + speed).
  box_hit u_paddle_hit (
    .a_x (nx),
    .a_y (to_calc(y_q) + SIZE_C),
    .a_w (SIZE_C),
    .a_h (speed + calc_t'(1)),
    .b_x (to_calc(bus.paddle_x)),
    .b_y (to_calc(bus.paddle_y)),
    .b_w (calc_t'(PADDLE_W)),
    .b_h (calc_t'(PADDLE_H + 1)),
    .hit (paddle_overlap)
  );

  // Current scan position against the ball square.
  box_hit u_pix_hit (
    .a_x (to_calc(bus.h_count)),
    .a_y (to_calc(bus.v_count)),
    .a_w (calc_t'(1)),
    .a_h (calc_t'(1)),
    .b_x (to_calc(x_q)),
    .b_y (to_calc(y_q)),
    .b_w (SIZE_C),
    .b_h (SIZE_C),
    .hit (pix_hit)
  );

  // Next position/direction: x and y rules resolve independently.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    x_n      = x_q;
    dx_n     = dx_q;
    y_n      = y_q;
    dy_n     = dy_q;
    bounce   = 1'b0;
    fall_out = 1'b0;

    if (nx < 0) begin
      x_n  = '0;
      dx_n = DIR_POS;
    end else if (nx > X_MAX_C) begin
      x_n  = coord_t'(X_MAX_C);
      dx_n = DIR_NEG;
    end else begin
      x_n = coord_t'(nx);
    end

    if (ny < 0) begin
      y_n  = '0;
      dy_n = DIR_POS;
    end else if (dy_q == DIR_POS && paddle_overlap) begin
      y_n    = coord_t'(to_calc(bus.paddle_y) - SIZE_C);
      dy_n   = DIR_NEG;
      bounce = 1'b1;
    end else if (ny + SIZE_C >= V_C) begin
      fall_out = 1'b1;
    end else begin
      y_n = coord_t'(ny);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: serve launches, falling out ends the rally for one clk.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.serve) state_d = MOVE;
      MOVE:    if (move_tick && fall_out) state_d = MISS;
      MISS:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy = (state_q == MOVE);
    miss = (state_q == MISS);
  end

  // Ball position/direction: reload on miss, advance on each moving frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q  <= X_RST;
      y_q  <= Y_RST;
      dx_q <= DIR_POS;
      dy_q <= DIR_NEG;
    end else if (state_q == MISS) begin
      x_q  <= X_RST;
      y_q  <= Y_RST;
      dx_q <= DIR_POS;
      dy_q <= DIR_NEG;
    end else if (move_tick) begin
      x_q  <= x_n;
      y_q  <= y_n;
      dx_q <= dx_n;
      dy_q <= dy_n;
    end
  end

  // Registered hit pulse and pixel flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      pix_q <= 1'b0;
    end else begin
      hit_q <= move_tick && bounce;
      pix_q <= pix_hit;
    end
  end

  assign bus.ball_x = x_q;
  assign bus.ball_y = y_q;
  assign bus.pix_on = pix_q;
  assign bus.hit    = hit_q;
  assign bus.miss   = miss;
  assign bus.busy   = busy;

endmodule
